// File: rtl/ps2_keys_pkg.sv
// Scan codes, direction bit indices, frame FSM encoding and code-to-direction
// mask helpers shared by the PS/2 direction source.
package ps2_keys_pkg;

  localparam logic [7:0] SC_PREFIX_E0 = 8'hE0;
  localparam logic [7:0] SC_BREAK_F0  = 8'hF0;

  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

  localparam logic [7:0] SC_KEY_W = 8'h1D;
  localparam logic [7:0] SC_KEY_S = 8'h1B;
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_D = 8'h23;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // One-hot direction for an E0-prefixed arrow code, zero when unmapped.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_ARROW_UP:    m[DIR_UP]    = 1'b1;
      SC_ARROW_DOWN:  m[DIR_DOWN]  = 1'b1;
      SC_ARROW_LEFT:  m[DIR_LEFT]  = 1'b1;
      SC_ARROW_RIGHT: m[DIR_RIGHT] = 1'b1;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_KEY_W: m[DIR_UP]    = 1'b1;
      SC_KEY_S: m[DIR_DOWN]  = 1'b1;
      SC_KEY_A: m[DIR_LEFT]  = 1'b1;
      SC_KEY_D: m[DIR_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, 11-bit frame FSM with
// odd-parity/stop checks and a mid-frame timeout. Emits one-cycle byte/error strobes.
module ps2_frame_rx
  import ps2_keys_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_error_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0]   clk_sync_q, data_sync_q;
  logic                     clk_prev_q;
  rx_state_e                state_q, state_d;
  logic [7:0]               shift_q, shift_d, byte_q;
  logic [2:0]               cnt_q, cnt_d;
  logic                     par_ok_q, par_ok_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                     valid_q, error_q, valid_s, error_s;
  logic                     clk_s, data_s, fall_s, tmo_hit_s;

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign fall_s    = clk_prev_q & ~clk_s;
  assign tmo_hit_s = (state_q != ST_IDLE) && !fall_s && (tmo_q == TMO_LAST);

  // Synchronisers reset to the idle-high line level so reset never fakes a fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      shift_q  <= 8'h00;
      cnt_q    <= 3'd0;
      par_ok_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_ok_q <= par_ok_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_ok_d = par_ok_q;
    tmo_d    = '0;
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_hit_s) begin
      state_d = ST_IDLE;
    end else if (!fall_s) begin
      tmo_d = tmo_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      tmo_d = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (fall_s && !data_s) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d = {data_s, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_ok_d = ^{data_s, shift_q};
          state_d  = ST_STOP;
        end else begin
          par_ok_d = par_ok_q;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_d = ST_IDLE;
        end else begin
          shift_d = shift_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_s = 1'b0;
    error_s = 1'b0;
    if (state_q == ST_STOP && fall_s) begin
      valid_s = data_s & par_ok_q;
      error_s = ~(data_s & par_ok_q);
    end else begin
      error_s = tmo_hit_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      valid_q <= valid_s;
      error_q <= error_s;
      byte_q  <= valid_s ? shift_q : byte_q;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign byte_error_o = error_q;

endmodule

// File: rtl/ps2_direction_source.sv
// PS/2 keyboard to held-direction vector (drop-in for push buttons).
// Optional WASD_KEYS_EN macro adds W/S/A/D as aliases of the arrow keys.
module ps2_direction_source
  import ps2_keys_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [3:0] PUSH_BUTTONS_OUT,
  output logic       KEY_EVENT,
  output logic       FRAME_ERROR
);

  logic [7:0] rx_byte_s;
  logic       byte_valid_s, byte_error_s;
  logic       e0_q, e0_d, f0_q, f0_d;
  logic [3:0] arrow_q, arrow_d, buttons_q, buttons_d;
  logic       key_event_q, frame_error_q;
`ifdef WASD_KEYS_EN
  logic [3:0] wasd_q, wasd_d;
`endif

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_rx (
    .clk_i       (CLOCK),
    .rst_i       (RESET),
    .ps2_clk_i   (PS2_CLK),
    .ps2_data_i  (PS2_DATA),
    .byte_o      (rx_byte_s),
    .byte_valid_o(byte_valid_s),
    .byte_error_o(byte_error_s)
  );

  // Prefix tracking and make/break decode; any non-prefix byte ends the sequence.
  always_comb begin
    e0_d    = e0_q;
    f0_d    = f0_q;
    arrow_d = arrow_q;
`ifdef WASD_KEYS_EN
    wasd_d  = wasd_q;
`endif
    if (byte_error_s) begin
      e0_d = 1'b0;
      f0_d = 1'b0;
    end else if (byte_valid_s) begin
      if (rx_byte_s == SC_PREFIX_E0) begin
        e0_d = 1'b1;
      end else if (rx_byte_s == SC_BREAK_F0) begin
        f0_d = 1'b1;
      end else begin
        if (e0_q) begin
          arrow_d = f0_q ? (arrow_q & ~arrow_mask(rx_byte_s))
                         : (arrow_q | arrow_mask(rx_byte_s));
        end else begin
`ifdef WASD_KEYS_EN
          wasd_d = f0_q ? (wasd_q & ~wasd_mask(rx_byte_s))
                        : (wasd_q | wasd_mask(rx_byte_s));
`else
          arrow_d = arrow_q;
`endif
        end
        e0_d = 1'b0;
        f0_d = 1'b0;
      end
    end else begin
      e0_d = e0_q;
      f0_d = f0_q;
    end
  end

`ifdef WASD_KEYS_EN
  assign buttons_d = arrow_d | wasd_d;
`else
  assign buttons_d = arrow_d;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      e0_q          <= 1'b0;
      f0_q          <= 1'b0;
      arrow_q       <= 4'b0000;
      buttons_q     <= 4'b0000;
      key_event_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      e0_q          <= e0_d;
      f0_q          <= f0_d;
      arrow_q       <= arrow_d;
      buttons_q     <= buttons_d;
      key_event_q   <= (buttons_d != buttons_q);
      frame_error_q <= byte_error_s;
    end
  end

`ifdef WASD_KEYS_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wasd_q <= 4'b0000;
    end else begin
      wasd_q <= wasd_d;
    end
  end
`endif

  assign PUSH_BUTTONS_OUT = buttons_q;
  assign KEY_EVENT        = key_event_q;
  assign FRAME_ERROR      = frame_error_q;

endmodule
